// File: rtl/bcd_pkg.sv
// Shared state encoding and default timing constants for the BCD display scheduler.
package bcd_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_SETUP   = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_WAIT    = 3'd4,
        ST_CAPTURE = 3'd5
    } state_e;

    localparam int FIFO_DEPTH_DEF  = 4;
    localparam int CONV_LAT_DEF    = 2;
    localparam int INIT_CYCLES_DEF = 2;
    localparam int CNT_W           = 8;

endpackage

// File: rtl/byte_fifo.sv
// Received-byte buffer: power-of-two ring with explicit occupancy count.
module byte_fifo
    import bcd_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [7:0]               din_i,
    input  logic                     pop_i,
    output logic [7:0]               dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ZERO_CNT = (AW + 1)'(0);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          do_push_s;
    logic          do_pop_s;

    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign do_pop_s  = pop_i && (count_q != ZERO_CNT);
    assign do_push_s = push_i && ((count_q != FULL_CNT) || do_pop_s);

    // Occupancy next-state.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and count.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= ZERO_CNT;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == ZERO_CNT);
    assign count_o = count_q;

endmodule

// File: rtl/bcd_conv_sched.sv
// Feeds buffered UART bytes one at a time through an external nibble converter
// and latches each result pair for the display.
module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
    parameter int CONV_LAT    = CONV_LAT_DEF,
    parameter int INIT_CYCLES = INIT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       conv_reset,
    output logic       conv_en,
    output logic [7:0] conv_hex,
    input  logic [3:0] conv_ones,
    input  logic [3:0] conv_tens,
    output logic [3:0] disp_ones,
    output logic [3:0] disp_tens,
    output logic       disp_valid,
    output logic       busy,
    output logic       fifo_full,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int               CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(CONV_LAT - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             conv_reset_q;
    logic             conv_en_q;
    logic [7:0]       conv_hex_q;
    logic [3:0]       disp_ones_q;
    logic [3:0]       disp_tens_q;
    logic             disp_valid_q;
    logic             busy_q;
    logic             overflow_q;

    logic [7:0]       fifo_head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CW-1:0]    fifo_count_s;
    logic             pop_s;
    logic             ovf_set_s;

    assign pop_s     = (state_q == ST_CAPTURE);
    assign ovf_set_s = rx_valid && fifo_full_s && !pop_s;

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_n_i (reset),
        .push_i  (rx_valid),
        .din_i   (rx_data),
        .pop_i   (pop_s),
        .dout_o  (fifo_head_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Conversion sequencer; every output is registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= CNT_W'(0);
            conv_reset_q <= 1'b1;
            conv_en_q    <= 1'b0;
            conv_hex_q   <= 8'h00;
            disp_ones_q  <= 4'h0;
            disp_tens_q  <= 4'h0;
            disp_valid_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            conv_en_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            case (state_q)
                ST_INIT: begin
                    if (cnt_q == INIT_LAST) begin
                        state_q      <= ST_IDLE;
                        cnt_q        <= CNT_W'(0);
                        conv_reset_q <= 1'b0;
                        busy_q       <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        state_q    <= ST_SETUP;
                        conv_hex_q <= fifo_head_s;
                        busy_q     <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    state_q   <= ST_ISSUE;
                    conv_en_q <= 1'b1;
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                    cnt_q   <= CNT_W'(0);
                end
                ST_WAIT: begin
                    if (cnt_q == WAIT_LAST) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    disp_ones_q  <= conv_ones;
                    disp_tens_q  <= conv_tens;
                    disp_valid_q <= 1'b1;
                    state_q      <= ST_IDLE;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q      <= ST_INIT;
                    cnt_q        <= CNT_W'(0);
                    conv_reset_q <= 1'b1;
                    busy_q       <= 1'b1;
                end
            endcase
        end
    end

    // Sticky drop flag; a new drop outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_q <= 1'b0;
        end else if (ovf_set_s) begin
            overflow_q <= 1'b1;
        end else if (ovf_clr) begin
            overflow_q <= 1'b0;
        end
    end

    assign conv_reset = conv_reset_q;
    assign conv_en    = conv_en_q;
    assign conv_hex   = conv_hex_q;
    assign disp_ones  = disp_ones_q;
    assign disp_tens  = disp_tens_q;
    assign disp_valid = disp_valid_q;
    assign busy       = busy_q;
    assign fifo_full  = (fifo_count_s == FULL_CNT);
    assign overflow   = overflow_q;

endmodule
